lomo_frame_rx: RTL and testbench

//  Receiver for the LOMO serial frame stream on the MK/CLK/DAT lines.

---
 rtl/lomo_frame_defs.sv | 26 ++
 rtl/lomo_sync_edge.sv | 42 ++++
 rtl/lomo_frame_rx.sv | 256 +++++++++++++++++++++++++
 tb/tb_lomo_frame_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lomo_frame_defs.sv
// Shared LOMO frame constants and the header word layout.
// Both the frame receiver and the frame generator use this package.
package lomo_frame_defs;

    localparam int LOMO_WORDS_STR    = 20;
    localparam int LOMO_STR_FRM      = 64;
    localparam int LOMO_HDR_HALF_IDX = 10;

    localparam int LOMO_HDR_FRM_W  = 9;
    localparam int LOMO_HDR_STR_W  = 6;
    localparam int LOMO_HDR_HALF_W = 1;

    // Receiver alignment state
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } rx_state_e;

    // Header word: {frame number, string number, half flag}, MSB first
    typedef struct packed {
        logic [LOMO_HDR_FRM_W-1:0]  frm;
        logic [LOMO_HDR_STR_W-1:0]  str;
        logic [LOMO_HDR_HALF_W-1:0] half;
    } lomo_hdr_t;

endpackage

// File: rtl/lomo_sync_edge.sv
// N-stage synchroniser for one asynchronous line, with one-clk rise and
// fall strobes taken from the synchronised output.
module lomo_sync_edge #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic [N-1:0] chain_q;
    logic [N-1:0] chain_d;
    logic         last_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chain
            if (gi == 0) begin : g_first
                assign chain_d[gi] = din_i;
            end else begin : g_next
                assign chain_d[gi] = chain_q[gi-1];
            end
        end
    endgenerate

    // Advance the synchroniser and keep one bit of history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            last_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            last_q  <= chain_q[N-1];
        end
    end

    assign rise_o = chain_q[N-1] & ~last_q;
    assign fall_o = ~chain_q[N-1] & last_q;

endmodule

// File: rtl/lomo_frame_rx.sv
// LOMO frame receiver: deserialises MSB-first 16-bit words on falling
// edges of the synchronised serial clock, aligns to the frame marker,
// tracks word/string/frame position and checks header words.
// Optional error counter: define LOMO_RX_ERRCNT_EN.
module lomo_frame_rx
    import lomo_frame_defs::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 4096,
    parameter int WORDS_STR   = LOMO_WORDS_STR,
    parameter int STR_FRM     = LOMO_STR_FRM
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MK,
    input  logic        CLK,
    input  logic        DAT,
    output logic [15:0] word_data,
    output logic        word_valid,
    output logic [4:0]  word_idx,
    output logic [5:0]  str_num,
    output logic [8:0]  frm_num,
    output logic        frame_start,
    output logic        locked,
    output logic        hdr_err,
    output logic        sync_err,
    output logic [15:0] err_cnt
);

    localparam int         TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0] IDX_LAST   = 5'(WORDS_STR - 1);
    localparam logic [4:0] HALF_IDX   = 5'(WORDS_STR / 2);
    localparam logic [5:0] STR_LAST   = 6'(STR_FRM - 1);

    // Synchronisers: CLK with edge strobes, MK/DAT as plain chains of equal depth
    logic clk_rise, clk_fall;
    logic [SYNC_STAGES-1:0] mk_chain_q, mk_chain_d, dat_chain_q, dat_chain_d;

    lomo_sync_edge #(.N(SYNC_STAGES)) u_clk_sync (
        .clk    (clk),
        .reset  (reset),
        .din_i  (CLK),
        .rise_o (clk_rise),
        .fall_o (clk_fall)
    );

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_md_chain
            if (gi == 0) begin : g_first
                assign mk_chain_d[gi]  = MK;
                assign dat_chain_d[gi] = DAT;
            end else begin : g_next
                assign mk_chain_d[gi]  = mk_chain_q[gi-1];
                assign dat_chain_d[gi] = dat_chain_q[gi-1];
            end
        end
    endgenerate

    // Advance MK/DAT synchronisers
    always_ff @(posedge clk) begin
        if (reset) begin
            mk_chain_q  <= '0;
            dat_chain_q <= '0;
        end else begin
            mk_chain_q  <= mk_chain_d;
            dat_chain_q <= dat_chain_d;
        end
    end

    logic mk_s, dat_s;
    assign mk_s  = mk_chain_q[SYNC_STAGES-1];
    assign dat_s = dat_chain_q[SYNC_STAGES-1];

    // Receiver state
    rx_state_e       state_q, state_d;
    logic [3:0]      bit_q, bit_d;
    logic [4:0]      idx_q, idx_d;
    logic [5:0]      str_q, str_d;
    logic [15:0]     shift_q, shift_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [8:0]      frm_q, frm_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [4:0]      widx_q, widx_d;
    logic [5:0]      wstr_q, wstr_d;
    logic            wvalid_q, wvalid_d;
    logic            fs_q, fs_d;
    logic            hdr_err_q, hdr_err_d;
    logic            sync_err_q, sync_err_d;
    logic            timeout_hit;

    logic [15:0] new_word;
    lomo_hdr_t   hdr;
    logic        first_word;
    logic        at_frame_start;

    assign new_word       = {shift_q[14:0], dat_s};
    assign hdr            = lomo_hdr_t'(new_word);
    assign first_word     = (idx_q == 5'd0) && (str_q == 6'd0);
    assign at_frame_start = (bit_q == 4'd15) && first_word;

    // Next-state: timeout timer, alignment, deserialiser, position and header checks
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        str_d       = str_q;
        shift_d     = shift_q;
        timer_d     = timer_q;
        frm_d       = frm_q;
        wdata_d     = wdata_q;
        widx_d      = widx_q;
        wstr_d      = wstr_q;
        wvalid_d    = 1'b0;
        fs_d        = 1'b0;
        hdr_err_d   = 1'b0;
        sync_err_d  = 1'b0;
        timeout_hit = 1'b0;

        // An edge in the expiry clk wins: it reloads instead of timing out
        if (state_q == ST_HUNT || clk_rise || clk_fall) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timeout_hit = 1'b1;
            timer_d     = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            ST_HUNT: begin
                if (clk_fall && mk_s) begin
                    state_d = ST_LOCKED;
                    shift_d = {15'd0, dat_s};
                    bit_d   = 4'd14;
                    idx_d   = 5'd0;
                    str_d   = 6'd0;
                end
            end
            ST_LOCKED: begin
                if (timeout_hit) begin
                    state_d = ST_HUNT;
                    bit_d   = 4'd0;
                    idx_d   = 5'd0;
                    str_d   = 6'd0;
                    shift_d = '0;
                end else if (clk_fall) begin
                    if (mk_s && !at_frame_start) begin
                        // Marker out of place: drop partial word, restart at frame start
                        sync_err_d = 1'b1;
                        shift_d    = {15'd0, dat_s};
                        bit_d      = 4'd14;
                        idx_d      = 5'd0;
                        str_d      = 6'd0;
                    end else begin
                        shift_d = new_word;
                        if (bit_q == 4'd0) begin
                            wvalid_d = 1'b1;
                            wdata_d  = new_word;
                            widx_d   = idx_q;
                            wstr_d   = str_q;
                            fs_d     = first_word;
                            bit_d    = 4'd15;
                            if (idx_q == 5'd0 || idx_q == HALF_IDX) begin
                                if (first_word) begin
                                    frm_d = hdr.frm;
                                end else if (hdr.frm != frm_q) begin
                                    hdr_err_d = 1'b1;
                                end
                                if (hdr.str != str_q) begin
                                    hdr_err_d = 1'b1;
                                end
                                if (hdr.half != (idx_q == 5'd0)) begin
                                    hdr_err_d = 1'b1;
                                end
                            end
                            if (idx_q == IDX_LAST) begin
                                idx_d = 5'd0;
                                str_d = (str_q == STR_LAST) ? 6'd0 : str_q + 6'd1;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end else begin
                            bit_d = bit_q - 4'd1;
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            bit_q      <= '0;
            idx_q      <= '0;
            str_q      <= '0;
            shift_q    <= '0;
            timer_q    <= '0;
            frm_q      <= '0;
            wdata_q    <= '0;
            widx_q     <= '0;
            wstr_q     <= '0;
            wvalid_q   <= 1'b0;
            fs_q       <= 1'b0;
            hdr_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            str_q      <= str_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            frm_q      <= frm_d;
            wdata_q    <= wdata_d;
            widx_q     <= widx_d;
            wstr_q     <= wstr_d;
            wvalid_q   <= wvalid_d;
            fs_q       <= fs_d;
            hdr_err_q  <= hdr_err_d;
            sync_err_q <= sync_err_d;
        end
    end

`ifdef LOMO_RX_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of clks carrying a header error, sync error or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if ((hdr_err_d || sync_err_d || timeout_hit) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'd0;
`endif

    assign word_data   = wdata_q;
    assign word_valid  = wvalid_q;
    assign word_idx    = widx_q;
    assign str_num     = wstr_q;
    assign frm_num     = frm_q;
    assign frame_start = fs_q;
    assign locked      = (state_q == ST_LOCKED);
    assign hdr_err     = hdr_err_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_lomo_frame_rx.sv
// Directed testbench for lomo_frame_rx: drives the MK/CLK/DAT pins
// (one clk per CLK phase), records delivered words and checks them.
module tb_lomo_frame_rx;

    logic        clk;
    logic        reset;
    logic        MK, CLK, DAT;
    logic [15:0] word_data;
    logic        word_valid;
    logic [4:0]  word_idx;
    logic [5:0]  str_num;
    logic [8:0]  frm_num;
    logic        frame_start;
    logic        locked;
    logic        hdr_err;
    logic        sync_err;
    logic [15:0] err_cnt;

    lomo_frame_rx dut (
        .clk         (clk),
        .reset       (reset),
        .MK          (MK),
        .CLK         (CLK),
        .DAT         (DAT),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_idx    (word_idx),
        .str_num     (str_num),
        .frm_num     (frm_num),
        .frame_start (frame_start),
        .locked      (locked),
        .hdr_err     (hdr_err),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LOMO_RX_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        logic [4:0]  idx;
        logic [5:0]  str;
        logic        fs;
        logic        he;
    } wrec_t;

    wrec_t q[$];
    int    n_fs   = 0;
    int    n_herr = 0;
    int    n_sync = 0;
    int    total  = 0;
    int    bad    = 0;

    // Record every delivered word and count strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (word_valid === 1'b1) begin
            q.push_back('{d: word_data, idx: word_idx, str: str_num, fs: frame_start, he: hdr_err});
        end
        if (frame_start === 1'b1) n_fs++;
        if (hdr_err === 1'b1) n_herr++;
        if (sync_err === 1'b1) n_sync++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_ec(input int n);
        return ERRCNT ? 16'(n) : 16'd0;
    endfunction

    function automatic logic [15:0] gen_word(input int frm, input int s, input int i);
        logic [8:0] f9;
        logic [5:0] s6;
        logic [4:0] i5;
        f9 = frm[8:0];
        s6 = s[5:0];
        i5 = i[4:0];
        if (i == 0)       return {f9, s6, 1'b1};
        else if (i == 10) return {f9, s6, 1'b0};
        else              return {4'hC, s6, 1'b0, i5};
    endfunction

    // One serial bit: DAT/MK change with CLK rising, held through the low phase
    task automatic send_bit(input logic d, input logic m);
        @(negedge clk);
        CLK = 1'b1;
        DAT = d;
        MK  = m;
        @(negedge clk);
        CLK = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int hi, input int lo, input bit mk_first);
        for (int b = hi; b >= lo; b--) begin
            send_bit(w[b], mk_first && (b == hi));
        end
    endtask

    task automatic send_word(input logic [15:0] w, input bit mk_first);
        send_bits(w, 15, 0, mk_first);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;
    int nmis;

    initial begin
        reset = 1'b1;
        MK    = 1'b0;
        CLK   = 1'b0;
        DAT   = 1'b0;
        idle(4);
        chk("rst_locked", locked, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_frm", frm_num, 0);
        chk("rst_errcnt", err_cnt, 0);
        reset = 1'b0;
        idle(4);

        // 1. Clean frame, frm=5
        for (int s = 0; s < 64; s++) begin
            for (int i = 0; i < 20; i++) begin
                send_word(gen_word(5, s, i), (s == 0) && (i == 0));
            end
        end
        idle(8);
        $display("frame 5 sent: words=%0d", q.size());
        chk("f1_count", q.size(), 1280);
        chk("f1_locked", locked, 1);
        chk("f1_first_data", q[0].d, 16'h0281);
        chk("f1_first_fs", q[0].fs, 1);
        chk("f1_frm", frm_num, 5);
        chk("f1_fs_count", n_fs, 1);
        chk("f1_herr", n_herr, 0);
        chk("f1_sync", n_sync, 0);
        chk("f1_errcnt", err_cnt, exp_ec(0));
        nmis = 0;
        for (int k = 0; k < 1280 && k < q.size(); k++) begin
            if (q[k].d !== gen_word(5, k / 20, k % 20) || q[k].idx !== 5'(k % 20) ||
                q[k].str !== 6'(k / 20) || q[k].he !== 1'b0) nmis++;
        end
        chk("f1_sequence", nmis, 0);

        // 2+3. Next frame (frm=6) after wrap; idx 10 of string 3 has half=1
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 20; i++) begin
                if (s == 3 && i == 10) send_word({9'd6, 6'd3, 1'b1}, 1'b0);
                else                   send_word(gen_word(6, s, i), (s == 0) && (i == 0));
            end
        end
        idle(8);
        $display("frame 6 strings 0-3 sent: words=%0d", q.size());
        chk("f2_count", q.size(), 1360);
        chk("f2_last_str63", q[1279].str, 63);
        chk("f2_wrap_str", q[1280].str, 0);
        chk("f2_wrap_idx", q[1280].idx, 0);
        chk("f2_hdr_data", q[1280].d, 16'h0301);
        chk("f2_fs", q[1280].fs, 1);
        chk("f2_fs_count", n_fs, 2);
        chk("f2_frm", frm_num, 6);
        chk("f3_herr_count", n_herr, 1);
        chk("f3_herr_word", q[1350].he, 1);
        chk("f3_herr_data", q[1350].d, 16'h0307);
        chk("f3_locked", locked, 1);
        chk("f3_errcnt", err_cnt, exp_ec(1));

        // 4. MK at bit 7 of idx 4, string 4; realign on a {7,0,1} header
        for (int i = 0; i < 4; i++) send_word(gen_word(6, 4, i), 1'b0);
        idle(8);
        base = q.size();
        chk("f4_pre_count", base, 1364);
        send_bits(gen_word(6, 4, 4), 15, 8, 1'b0);
        send_word(16'h0381, 1'b1);
        idle(8);
        $display("resync word sent: words=%0d sync_err=%0d", q.size(), n_sync);
        chk("f4_sync", n_sync, 1);
        chk("f4_one_word", q.size(), base + 1);
        chk("f4_data", q[q.size()-1].d, 16'h0381);
        chk("f4_idx", q[q.size()-1].idx, 0);
        chk("f4_str", q[q.size()-1].str, 0);
        chk("f4_fs", q[q.size()-1].fs, 1);
        chk("f4_frm", frm_num, 7);
        chk("f4_errcnt", err_cnt, exp_ec(2));
        send_word(gen_word(7, 0, 1), 1'b0);
        send_word(gen_word(7, 0, 2), 1'b0);
        idle(8);
        chk("f4_follow_count", q.size(), base + 3);
        chk("f4_follow_idx", q[q.size()-1].idx, 2);

        // 5. Stop CLK mid-word past the timeout, then restart without MK
        send_bits(gen_word(7, 0, 3), 15, 8, 1'b0);
        idle(4096 + 8);
        $display("clock stopped: locked=%0d words=%0d", locked, q.size());
        chk("f5_locked", locked, 0);
        chk("f5_no_partial", q.size(), base + 3);
        chk("f5_errcnt", err_cnt, exp_ec(3));
        for (int k = 0; k < 40; k++) send_bit(k[0] ^ k[2], 1'b0);
        idle(8);
        chk("f5_restart_words", q.size(), base + 3);
        chk("f5_restart_locked", locked, 0);

        // 6. New frame (frm=8), reset for one clk in the middle of word 12
        send_word(gen_word(8, 0, 0), 1'b1);
        for (int i = 1; i < 12; i++) send_word(gen_word(8, 0, i), 1'b0);
        send_bits(gen_word(8, 0, 12), 15, 11, 1'b0);
        chk("f6_count", q.size(), base + 15);
        chk("f6_frm", frm_num, 8);
        chk("f6_herr", n_herr, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset pulsed: locked=%0d valid=%0d frm=%0d", locked, word_valid, frm_num);
        chk("f6_rst_locked", locked, 0);
        chk("f6_rst_valid", word_valid, 0);
        chk("f6_rst_data", word_data, 0);
        chk("f6_rst_idx", word_idx, 0);
        chk("f6_rst_str", str_num, 0);
        chk("f6_rst_frm", frm_num, 0);
        chk("f6_rst_fs", frame_start, 0);
        chk("f6_rst_herr", hdr_err, 0);
        chk("f6_rst_sync", sync_err, 0);
        chk("f6_rst_errcnt", err_cnt, 0);
        send_bits(gen_word(8, 0, 12), 10, 0, 1'b0);
        send_word(gen_word(8, 0, 13), 1'b0);
        send_word(gen_word(8, 0, 14), 1'b0);
        idle(8);
        chk("f6_hunt_words", q.size(), base + 15);
        chk("f6_hunt_locked", locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
